npu_readmem_sweep_sched: RTL and testbench

//  Sequences NPU v2 read-memory sweeps: walks WL (outer) x BL (inner) over a configured

---
 rtl/npu_readmem_sweep_sched_if.sv | 58 +++++
 rtl/npu_readmem_sweep_sched.sv | 184 ++++++++++++++++++
 tb/tb_npu_readmem_sweep_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_readmem_sweep_sched_if.sv
// npu_readmem_sweep_sched_if
// Purpose: bundles the config, control, read-engine and result-buffer signals
//          of the NPU read-memory sweep scheduler into one interface.
//          Signal prefixes (i_/o_) are from the scheduler's point of view.
// Signals:
//   i_start, i_stop           start / abort pulses
//   i_cfg_wl_st/i_cfg_wl_end  WL range;  i_cfg_bl_st/i_cfg_bl_end  BL range
//   i_cfg_repeat, i_cfg_loop  reads per point, extra whole-range passes
//   o_rd_req, o_rd_wl/o_rd_bl read request and its point
//   i_rd_done, i_rd_dout      engine completion and ADC sample
//   o_res_we/addr/data        output buffer write port
//   o_busy, o_done            status
//   o_cur_wl/bl/loop          current (or last) point and pass
// Modports: master = scheduler side, slave = config/engine/buffer side.
interface npu_readmem_sweep_sched_if #(
  parameter int POS_W   = 8,
  parameter int DOUT_W  = 6,
  parameter int REP_W   = 4,
  parameter int ACC_W   = 10,
  parameter int LOOP_W  = 32,
  parameter int OADDR_W = 9
);
  logic               i_start;
  logic               i_stop;
  logic [POS_W-1:0]   i_cfg_wl_st;
  logic [POS_W-1:0]   i_cfg_wl_end;
  logic [POS_W-1:0]   i_cfg_bl_st;
  logic [POS_W-1:0]   i_cfg_bl_end;
  logic [REP_W-1:0]   i_cfg_repeat;
  logic [LOOP_W-1:0]  i_cfg_loop;
  logic               o_rd_req;
  logic [POS_W-1:0]   o_rd_wl;
  logic [POS_W-1:0]   o_rd_bl;
  logic               i_rd_done;
  logic [DOUT_W-1:0]  i_rd_dout;
  logic               o_res_we;
  logic [OADDR_W-1:0] o_res_addr;
  logic [ACC_W-1:0]   o_res_data;
  logic               o_busy;
  logic               o_done;
  logic [POS_W-1:0]   o_cur_wl;
  logic [POS_W-1:0]   o_cur_bl;
  logic [LOOP_W-1:0]  o_cur_loop;

  modport master (
    input  i_start, i_stop, i_cfg_wl_st, i_cfg_wl_end, i_cfg_bl_st, i_cfg_bl_end,
           i_cfg_repeat, i_cfg_loop, i_rd_done, i_rd_dout,
    output o_rd_req, o_rd_wl, o_rd_bl, o_res_we, o_res_addr, o_res_data,
           o_busy, o_done, o_cur_wl, o_cur_bl, o_cur_loop
  );

  modport slave (
    output i_start, i_stop, i_cfg_wl_st, i_cfg_wl_end, i_cfg_bl_st, i_cfg_bl_end,
           i_cfg_repeat, i_cfg_loop, i_rd_done, i_rd_dout,
    input  o_rd_req, o_rd_wl, o_rd_bl, o_res_we, o_res_addr, o_res_data,
           o_busy, o_done, o_cur_wl, o_cur_bl, o_cur_loop
  );
endinterface

// File: rtl/npu_readmem_sweep_sched.sv
// npu_readmem_sweep_sched
// Purpose: sequences NPU v2 read-memory sweeps. Walks WL (outer) x BL (inner)
//          over a latched rectangle, issues cfg_repeat read requests per point
//          to the read engine, sums the returned DOUT samples and writes each
//          per-point sum into the output buffer. Optionally repeats the whole
//          rectangle cfg_loop extra times. A stop pulse aborts cleanly, draining
//          any outstanding engine request first.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus     npu_readmem_sweep_sched_if.master (config, engine, buffer, status)
module npu_readmem_sweep_sched #(
  parameter int POS_W   = 8,
  parameter int DOUT_W  = 6,
  parameter int REP_W   = 4,
  parameter int ACC_W   = 10,
  parameter int LOOP_W  = 32,
  parameter int OADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  npu_readmem_sweep_sched_if.master bus
);

  // GAP keeps rd_req low for one cycle between back-to-back repeats.
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_WRITE, S_DONE, S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [POS_W-1:0]   r_wl_st, r_wl_end, r_bl_st, r_bl_end;
  logic [REP_W-1:0]   r_rep_tgt;
  logic [LOOP_W-1:0]  r_loop_tgt;

  logic [POS_W-1:0]   r_wl, r_bl;
  logic [LOOP_W-1:0]  r_loop;
  logic [REP_W-1:0]   r_rep;
  logic [OADDR_W-1:0] r_addr;
  logic [ACC_W-1:0]   r_acc;

  logic               w_start_ok;
  logic               w_rd_accept;
  logic [REP_W-1:0]   w_rep_inc;
  logic               w_rep_last;
  logic               w_bl_last, w_wl_last, w_loop_last, w_sweep_last;
  logic [ACC_W-1:0]   w_dout_ext;

  assign w_start_ok   = bus.i_start & ~bus.i_stop;
  // An engine may answer in the same cycle the request first appears.
  assign w_rd_accept  = bus.i_rd_done & ((r_state == S_ISSUE) | (r_state == S_WAIT));
  assign w_rep_inc    = r_rep + REP_W'(1);
  assign w_rep_last   = (w_rep_inc == r_rep_tgt);
  assign w_bl_last    = (r_bl == r_bl_end);
  assign w_wl_last    = (r_wl == r_wl_end);
  assign w_loop_last  = (r_loop == r_loop_tgt);
  assign w_sweep_last = w_bl_last & w_wl_last & w_loop_last;
  assign w_dout_ext   = {{(ACC_W-DOUT_W){1'b0}}, bus.i_rd_dout};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next         = r_state;
    bus.o_rd_req   = 1'b0;
    bus.o_res_we   = 1'b0;
    bus.o_res_data = '0;
    bus.o_busy     = (r_state != S_IDLE);
    bus.o_done     = 1'b0;
    bus.o_rd_wl    = r_wl;
    bus.o_rd_bl    = r_bl;
    bus.o_res_addr = r_addr;
    bus.o_cur_wl   = r_wl;
    bus.o_cur_bl   = r_bl;
    bus.o_cur_loop = r_loop;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.o_rd_req = 1'b1;
        if (bus.i_stop)         w_next = S_IDLE;
        else if (bus.i_rd_done) w_next = w_rep_last ? S_WRITE : S_GAP;
        else                    w_next = S_WAIT;
      end
      S_WAIT: begin
        bus.o_rd_req = 1'b1;
        if (bus.i_rd_done)   w_next = bus.i_stop ? S_IDLE : (w_rep_last ? S_WRITE : S_GAP);
        else if (bus.i_stop) w_next = S_DRAIN;
      end
      S_GAP: begin
        w_next = bus.i_stop ? S_IDLE : S_ISSUE;
      end
      S_WRITE: begin
        // An abort landing on the write cycle suppresses the write.
        bus.o_res_we   = ~bus.i_stop;
        bus.o_res_data = bus.i_stop ? '0 : r_acc;
        if (bus.i_stop)        w_next = S_IDLE;
        else if (w_sweep_last) w_next = S_DONE;
        else                   w_next = S_ISSUE;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        w_next     = S_IDLE;
      end
      S_DRAIN: begin
        bus.o_rd_req = 1'b1;
        if (bus.i_rd_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Config latch, point walk, repeat count and accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wl_st    <= '0;
      r_wl_end   <= '0;
      r_bl_st    <= '0;
      r_bl_end   <= '0;
      r_rep_tgt  <= '0;
      r_loop_tgt <= '0;
      r_wl       <= '0;
      r_bl       <= '0;
      r_loop     <= '0;
      r_rep      <= '0;
      r_addr     <= '0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            // A reversed range collapses to its start point.
            r_wl_st    <= bus.i_cfg_wl_st;
            r_wl_end   <= (bus.i_cfg_wl_end < bus.i_cfg_wl_st) ? bus.i_cfg_wl_st : bus.i_cfg_wl_end;
            r_bl_st    <= bus.i_cfg_bl_st;
            r_bl_end   <= (bus.i_cfg_bl_end < bus.i_cfg_bl_st) ? bus.i_cfg_bl_st : bus.i_cfg_bl_end;
            r_rep_tgt  <= (bus.i_cfg_repeat == '0) ? REP_W'(1) : bus.i_cfg_repeat;
            r_loop_tgt <= bus.i_cfg_loop;
            r_wl       <= bus.i_cfg_wl_st;
            r_bl       <= bus.i_cfg_bl_st;
            r_loop     <= '0;
            r_rep      <= '0;
            r_addr     <= '0;
            r_acc      <= '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_rd_accept) begin
            r_acc <= r_acc + w_dout_ext;
            r_rep <= w_rep_inc;
          end
        end
        S_WRITE: begin
          // The final point is left in place so status shows the last point/pass.
          if (!bus.i_stop && !w_sweep_last) begin
            r_acc  <= '0;
            r_rep  <= '0;
            r_addr <= r_addr + OADDR_W'(1);
            if (w_bl_last) begin
              r_bl <= r_bl_st;
              if (w_wl_last) begin
                r_wl   <= r_wl_st;
                r_loop <= r_loop + LOOP_W'(1);
                r_addr <= '0;
              end else begin
                r_wl <= r_wl + POS_W'(1);
              end
            end else begin
              r_bl <= r_bl + POS_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_readmem_sweep_sched.sv
// tb_npu_readmem_sweep_sched
// Purpose: directed self-checking bench for npu_readmem_sweep_sched. A small
//          read-engine model answers requests after a fixed or random delay
//          with a sample derived from the requested point; a monitor collects
//          result-buffer writes and done pulses for comparison against
//          hand-computed expectations.
module tb_npu_readmem_sweep_sched;

  logic clk;
  logic rst_n;

  int checkCount = 0;
  int failCount  = 0;
  int cycleCount = 0;

  // Engine model controls and request log.
  int         doutMode  = 0;
  logic [5:0] constDout = '0;
  int         engDelay  = 1;
  bit         engRandom = 1'b0;
  int         reqCount  = 0;
  logic [7:0] reqWl[$];
  logic [7:0] reqBl[$];

  // Monitor log.
  logic [8:0] wrAddr[$];
  logic [9:0] wrData[$];
  int         lastWrCycle = 0;
  int         doneCount   = 0;
  int         doneCycle   = 0;

  npu_readmem_sweep_sched_if bus ();

  npu_readmem_sweep_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used to time done relative to the last write.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Sample returned by the engine model for a given point.
  function automatic logic [5:0] doutFor(input logic [7:0] wl, input logic [7:0] bl);
    int w;
    int b;
    w = int'(wl);
    b = int'(bl);
    if (doutMode == 0)      return bl[5:0];
    else if (doutMode == 1) return constDout;
    else                    return 6'((w * 3 + b) % 64);
  endfunction

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Read engine: notice a request, wait, return one sample. A request that
  // disappears while waiting (reset or abort) is dropped without a response.
  initial begin : engine
    int         d;
    logic [7:0] wl;
    logic [7:0] bl;
    bit         dropped;
    bus.i_rd_done = 1'b0;
    bus.i_rd_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.o_rd_req) begin
        wl = bus.o_rd_wl;
        bl = bus.o_rd_bl;
        reqCount++;
        reqWl.push_back(wl);
        reqBl.push_back(bl);
        d = engRandom ? int'($urandom_range(0, 20)) : engDelay;
        dropped = 1'b0;
        for (int i = 0; i < d && !dropped; i++) begin
          @(posedge clk); #1;
          if (!bus.o_rd_req) dropped = 1'b1;
        end
        if (!dropped) begin
          bus.i_rd_dout = doutFor(wl, bl);
          bus.i_rd_done = 1'b1;
          @(posedge clk); #1;
          bus.i_rd_done = 1'b0;
        end
      end
    end
  end

  // Result-buffer and done monitor, sampled mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.o_res_we) begin
        wrAddr.push_back(bus.o_res_addr);
        wrData.push_back(bus.o_res_data);
        lastWrCycle = cycleCount;
      end
      if (bus.o_done) begin
        doneCount++;
        doneCycle = cycleCount;
      end
    end
  end

  // Load a config, pulse start for one cycle, then scramble the config inputs
  // so that any dependence on live config shows up in the results.
  task automatic applyStimulus(input logic [7:0] wlSt, input logic [7:0] wlEnd,
                               input logic [7:0] blSt, input logic [7:0] blEnd,
                               input logic [3:0] rep, input logic [31:0] loops);
    @(posedge clk); #1;
    reqCount  = 0;
    doneCount = 0;
    reqWl.delete();
    reqBl.delete();
    wrAddr.delete();
    wrData.delete();
    bus.i_cfg_wl_st  = wlSt;
    bus.i_cfg_wl_end = wlEnd;
    bus.i_cfg_bl_st  = blSt;
    bus.i_cfg_bl_end = blEnd;
    bus.i_cfg_repeat = rep;
    bus.i_cfg_loop   = loops;
    bus.i_start      = 1'b1;
    @(posedge clk); #1;
    bus.i_start      = 1'b0;
    bus.i_cfg_wl_st  = 8'hF0;
    bus.i_cfg_wl_end = 8'hF3;
    bus.i_cfg_bl_st  = 8'h80;
    bus.i_cfg_bl_end = 8'h83;
    bus.i_cfg_repeat = 4'd9;
    bus.i_cfg_loop   = 32'd3;
  endtask

  // Wait (bounded) for the done pulse, then step one cycle past it.
  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(bus.o_done), 64'd1);
    @(negedge clk); #1;
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int  exp4[4];
    int  idx;
    bit  reqHeld;
    bit  sawDone;

    exp4 = '{6, 7, 9, 10};

    rst_n            = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_cfg_wl_st  = '0;
    bus.i_cfg_wl_end = '0;
    bus.i_cfg_bl_st  = '0;
    bus.i_cfg_bl_end = '0;
    bus.i_cfg_repeat = '0;
    bus.i_cfg_loop   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",   64'(bus.o_busy),   64'd0);
    checkOutput("rst_rd_req", 64'(bus.o_rd_req), 64'd0);
    checkOutput("rst_res_we", 64'(bus.o_res_we), 64'd0);
    checkOutput("rst_done",   64'(bus.o_done),   64'd0);
    rst_n = 1'b1;

    // 1: single WL row, BL 0..5, 5 repeats, dout = bl.
    $display("[TB] test 1: row sweep with repeats");
    doutMode = 0;
    engDelay = 2;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd5, 4'd5, 32'd0);
    checkOutput("t1_latency_busy", 64'(bus.o_busy),   64'd1);
    checkOutput("t1_latency_req",  64'(bus.o_rd_req), 64'd1);
    waitDone("t1_done", 2000);
    checkOutput("t1_write_count", 64'(wrData.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wrData.size()) begin
        checkOutput("t1_addr", 64'(wrAddr[i]), 64'(i));
        checkOutput("t1_data", 64'(wrData[i]), 64'(5 * i));
      end
    end
    checkOutput("t1_req_count",  64'(reqCount), 64'd30);
    checkOutput("t1_done_after", 64'(doneCycle - lastWrCycle), 64'd1);
    checkOutput("t1_done_count", 64'(doneCount), 64'd1);
    checkOutput("t1_cur_bl",     64'(bus.o_cur_bl),   64'd5);
    checkOutput("t1_cur_loop",   64'(bus.o_cur_loop), 64'd0);
    checkOutput("t1_idle_busy",  64'(bus.o_busy),     64'd0);

    // 2: repeat 0 on a single point behaves as one read.
    $display("[TB] test 2: repeat zero, single point");
    doutMode  = 1;
    constDout = 6'd33;
    engDelay  = 1;
    applyStimulus(8'd4, 8'd4, 8'd9, 8'd9, 4'd0, 32'd0);
    waitDone("t2_done", 500);
    checkOutput("t2_req_count",   64'(reqCount),      64'd1);
    checkOutput("t2_write_count", 64'(wrData.size()), 64'd1);
    if (wrData.size() > 0) begin
      checkOutput("t2_data", 64'(wrData[0]), 64'd33);
      checkOutput("t2_addr", 64'(wrAddr[0]), 64'd0);
    end
    checkOutput("t2_done_count", 64'(doneCount), 64'd1);

    // 3: reversed BL range collapses to bl_st; engine answers immediately.
    $display("[TB] test 3: reversed BL range");
    doutMode = 2;
    engDelay = 0;
    applyStimulus(8'd2, 8'd3, 8'd7, 8'd6, 4'd1, 32'd0);
    waitDone("t3_done", 500);
    checkOutput("t3_write_count", 64'(wrData.size()), 64'd2);
    checkOutput("t3_req_count",   64'(reqCount),      64'd2);
    if (reqWl.size() >= 2) begin
      checkOutput("t3_req0_wl", 64'(reqWl[0]), 64'd2);
      checkOutput("t3_req0_bl", 64'(reqBl[0]), 64'd7);
      checkOutput("t3_req1_wl", 64'(reqWl[1]), 64'd3);
      checkOutput("t3_req1_bl", 64'(reqBl[1]), 64'd7);
    end
    if (wrData.size() >= 2) begin
      checkOutput("t3_addr0", 64'(wrAddr[0]), 64'd0);
      checkOutput("t3_data0", 64'(wrData[0]), 64'd13);
      checkOutput("t3_addr1", 64'(wrAddr[1]), 64'd1);
      checkOutput("t3_data1", 64'(wrData[1]), 64'd16);
    end

    // 4: 2x2 grid, three passes; a stray start mid-sweep must be ignored.
    $display("[TB] test 4: grid with loops");
    engDelay = 1;
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 4'd1, 32'd2);
    repeat (4) @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    waitDone("t4_done", 2000);
    checkOutput("t4_write_count", 64'(wrData.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < wrData.size()) begin
        checkOutput("t4_addr", 64'(wrAddr[i]), 64'(i % 4));
        checkOutput("t4_data", 64'(wrData[i]), 64'(exp4[i % 4]));
      end
    end
    checkOutput("t4_cur_loop",   64'(bus.o_cur_loop), 64'd2);
    checkOutput("t4_cur_wl",     64'(bus.o_cur_wl),   64'd2);
    checkOutput("t4_cur_bl",     64'(bus.o_cur_bl),   64'd4);
    checkOutput("t4_done_count", 64'(doneCount),      64'd1);

    // start together with stop in IDLE is not accepted.
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    checkOutput("startstop_busy", 64'(bus.o_busy),   64'd0);
    checkOutput("startstop_req",  64'(bus.o_rd_req), 64'd0);

    // 5: abort while waiting on the engine.
    $display("[TB] test 5: abort during wait");
    doutMode = 0;
    engDelay = 12;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd3, 4'd2, 32'd0);
    repeat (2) @(posedge clk);
    #1 bus.i_stop = 1'b1;
    @(posedge clk);
    #1 bus.i_stop = 1'b0;
    reqHeld = 1'b1;
    sawDone = 1'b0;
    for (int n = 0; n < 40 && !sawDone; n++) begin
      @(negedge clk);
      if (!bus.o_rd_req) reqHeld = 1'b0;
      if (bus.i_rd_done) sawDone = 1'b1;
    end
    checkOutput("t5_rd_done_seen", 64'(sawDone), 64'd1);
    checkOutput("t5_req_held",     64'(reqHeld), 64'd1);
    @(negedge clk); #1;
    checkOutput("t5_busy_low",   64'(bus.o_busy),    64'd0);
    checkOutput("t5_req_low",    64'(bus.o_rd_req),  64'd0);
    checkOutput("t5_no_write",   64'(wrData.size()), 64'd0);
    checkOutput("t5_no_done",    64'(doneCount),     64'd0);
    engDelay = 3;
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd1, 4'd2, 32'd0);
    waitDone("t5_rerun_done", 500);
    checkOutput("t5_rerun_writes", 64'(wrData.size()), 64'd2);
    if (wrData.size() >= 2) begin
      checkOutput("t5_rerun_data0", 64'(wrData[0]), 64'd0);
      checkOutput("t5_rerun_data1", 64'(wrData[1]), 64'd2);
    end

    // 6: asynchronous reset mid-wait, then a random-latency sweep.
    $display("[TB] test 6: reset mid-wait and random engine latency");
    doutMode = 2;
    engDelay = 8;
    applyStimulus(8'd1, 8'd1, 8'd4, 8'd7, 4'd3, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("t6_pre_req",  64'(bus.o_rd_req), 64'd1);
    checkOutput("t6_pre_cur",  64'(bus.o_cur_bl), 64'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_req",    64'(bus.o_rd_req), 64'd0);
    checkOutput("t6_rst_busy",   64'(bus.o_busy),   64'd0);
    checkOutput("t6_rst_cur_wl", 64'(bus.o_cur_wl), 64'd0);
    checkOutput("t6_rst_cur_bl", 64'(bus.o_cur_bl), 64'd0);
    checkOutput("t6_rst_rd_bl",  64'(bus.o_rd_bl),  64'd0);
    checkOutput("t6_rst_we",     64'(bus.o_res_we), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    engRandom = 1'b1;
    applyStimulus(8'd0, 8'd2, 8'd5, 8'd7, 4'd3, 32'd1);
    waitDone("t6_done", 5000);
    checkOutput("t6_req_count",   64'(reqCount),      64'd54);
    checkOutput("t6_write_count", 64'(wrData.size()), 64'd18);
    idx = 0;
    for (int lp = 0; lp < 2; lp++) begin
      for (int w = 0; w <= 2; w++) begin
        for (int b = 5; b <= 7; b++) begin
          if (idx < wrData.size()) begin
            checkOutput("t6_addr", 64'(wrAddr[idx]), 64'(idx % 9));
            checkOutput("t6_data", 64'(wrData[idx]), 64'(3 * (w * 3 + b)));
          end
          idx++;
        end
      end
    end
    checkOutput("t6_done_count", 64'(doneCount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
